// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART byte transmitter among NREQ requesters.
// Latency: req seen in IDLE at cycle T -> tx_flag/ack at T+1; per byte adds LOAD+WAIT_START+SELECT+GAP_CYCLES.
// Backpressure: waits on tx_busy before launching; the owner holds the lock while its req is low (no timeout).
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int GAP_CYCLES    = 0,
  parameter int START_TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_flag,
  input  logic              tx_busy,
  output logic              active,
  output logic              start_err
);

  localparam int PW  = $clog2(NREQ);
  localparam int PW1 = PW + 1;
  localparam int TW  = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    LOAD       = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4,
    GAP        = 3'd5
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ack_q;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   ptr_q;
  logic [7:0]      tx_data_q;
  logic            tx_flag_q;
  logic            last_q;
  logic            start_err_q;
  logic [TW-1:0]   tmo_q;
  logic [GW-1:0]   gcnt_q;

  logic            win_found_d;
  logic [PW-1:0]   win_idx_d;
  logic [PW:0]     scan_d;
  logic [NREQ-1:0] win_onehot_d;
  logic [7:0]      win_byte_d;
  logic [7:0]      own_byte_d;
  logic [PW-1:0]   ptr_inc_d;

  // Round-robin search: first requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    scan_d      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_d = {1'b0, ptr_q} + PW1'(k);
      if (scan_d >= PW1'(NREQ)) begin
        scan_d = scan_d - PW1'(NREQ);
      end
      if (!win_found_d && req[scan_d[PW-1:0]]) begin
        win_found_d = 1'b1;
        win_idx_d   = scan_d[PW-1:0];
      end
    end
  end

  assign win_onehot_d = NREQ'(1) << win_idx_d;
  assign win_byte_d   = data[win_idx_d*8 +: 8];
  assign own_byte_d   = data[gidx_q*8 +: 8];
  // Pointer moves just past the owner when its packet finishes or is dropped.
  assign ptr_inc_d    = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);

  // Arbitration FSM; tx_flag/ack/start_err are one-cycle registered pulses.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      tx_data_q   <= 8'hFF;
      tx_flag_q   <= 1'b0;
      last_q      <= 1'b0;
      start_err_q <= 1'b0;
      tmo_q       <= '0;
      gcnt_q      <= '0;
    end else begin
      ack_q       <= '0;
      tx_flag_q   <= 1'b0;
      start_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found_d && !tx_busy) begin
            grant_q   <= win_onehot_d;
            gidx_q    <= win_idx_d;
            tx_data_q <= win_byte_d;
            last_q    <= last[win_idx_d];
            ack_q     <= win_onehot_d;
            tx_flag_q <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          tmo_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmo_q == TW'(START_TIMEOUT - 2)) begin
            // The count would reach START_TIMEOUT-1 on this cycle: give up on the byte.
            start_err_q <= 1'b1;
            grant_q     <= '0;
            ptr_q       <= ptr_inc_d;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            gcnt_q  <= '0;
            state_q <= (GAP_CYCLES > 0) ? GAP : SELECT;
          end
        end
        GAP: begin
          if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= SELECT;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        SELECT: begin
          if (last_q) begin
            ptr_q   <= ptr_inc_d;
            grant_q <= '0;
            state_q <= IDLE;
          end else if (req[gidx_q]) begin
            tx_data_q <= own_byte_d;
            last_q    <= last[gidx_q];
            ack_q     <= grant_q;
            tx_flag_q <= 1'b1;
            state_q   <= LOAD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_flag   = tx_flag_q;
  assign active    = |grant_q;
  assign start_err = start_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transmitter model drive the main instance,
// a second instance with GAP_CYCLES=5 is driven directly. Launches are compared against an
// expected queue filled when each stimulus is issued.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GAPN = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ack, grant;
  logic [7:0]  tx_data;
  logic        tx_flag, tx_busy, active, start_err;

  logic [3:0]  g_req = '0;
  logic [31:0] g_data = '0;
  logic [3:0]  g_last = '0;
  logic [3:0]  g_ack, g_grant;
  logic [7:0]  g_txd;
  logic        g_flag, g_busy = 1'b0, g_active, g_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(0), .START_TIMEOUT(4)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .req(req), .data(data), .last(last), .ack(ack),
    .grant(grant), .tx_data(tx_data), .tx_flag(tx_flag), .tx_busy(tx_busy),
    .active(active), .start_err(start_err));

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAPN), .START_TIMEOUT(4)) u_gap (
    .CLK(clk), .RESET_N(rst_n), .req(g_req), .data(g_data), .last(g_last), .ack(g_ack),
    .grant(g_grant), .tx_data(g_txd), .tx_flag(g_flag), .tx_busy(g_busy),
    .active(g_active), .start_err(g_err));

  typedef struct { logic [3:0] g; logic [7:0] d; int c; } obs_t;
  typedef struct { logic [3:0] g; logic [7:0] d; } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  logic [3:0] err_grant = '0;
  int xcnt = 0;
  int wtime = 4;
  logic tx_en = 1'b1;

  logic [8:0] rq [NREQ][$];   // {last, byte} per requester
  obs_t obs_q[$];
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge model: record launches, check invariants, emulate transmitter and requesters.
  initial begin
    obs_t o;
    req = '0; data = '0; last = '0; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_flag === 1'b1) begin
        o.g = grant; o.d = tx_data; o.c = cyc;
        obs_q.push_back(o);
      end
      if (start_err === 1'b1) begin
        err_cnt++; err_cyc = cyc; err_grant = grant;
      end
      if (rst_n) begin
        if ((grant & (grant - 4'd1)) != 4'd0) viol++;
        if (ack != 4'd0 && (!tx_flag || ack != grant)) viol++;
        if (tx_flag && tx_busy) viol++;
        if (active != (grant != 4'd0)) viol++;
        if ((g_flag && g_busy) || (g_ack != 4'd0 && g_ack != g_grant)) viol++;
      end
      // Transmitter: busy rises the cycle after the strobe, holds for wtime cycles.
      if (tx_flag === 1'b1 && tx_en) xcnt = wtime + 1;
      else if (xcnt > 0) xcnt--;
      tx_busy = (xcnt > 0 && xcnt <= wtime);
      // Requesters: advance on ack, present the head of the queue.
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req[i] = 1'b1; data[8*i +: 8] = rq[i][0][7:0]; last[i] = rq[i][0][8];
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    g_req = '0; g_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (grant == 4'd0 && !tx_busy && req == 4'd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] b, input logic l);
    exp_t e;
    rq[i].push_back({l, b});
    e.g = 4'(1 << i); e.d = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'd0 || ack !== 4'd0) begin
      failures++; $display("FAIL reset_grant_ack: grant=%b ack=%b, want 0000/0000", grant, ack);
    end
    checks++;
    if (tx_data !== 8'hFF) begin
      failures++; $display("FAIL reset_tx_data: got %h, want ff", tx_data);
    end
    checks++;
    if ({tx_flag, active, start_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: flag/active/err=%b, want 000", {tx_flag, active, start_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok; int t0; int base;
    do_reset();
    wtime = 4; tx_en = 1'b1;
    base = obs_q.size();
    @(posedge clk); #1;
    t0 = cyc;
    push_req(0, 8'hA5, 1'b1);
    wait_obs(base + 1, 20, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_launch: no tx_flag within 20 cycles, want one");
    end else begin
      checks++;
      if (obs_q[base].g !== 4'b0001 || obs_q[base].d !== 8'hA5) begin
        failures++; $display("FAIL single_byte: grant=%b data=%h, want 0001/a5", obs_q[base].g, obs_q[base].d);
      end
      checks++;
      if (obs_q[base].c - t0 != 1) begin
        failures++; $display("FAIL single_latency: %0d cycles, want 1", obs_q[base].c - t0);
      end
    end
    wait_idle(40, ok);
    checks++;
    if (!ok || active !== 1'b0 || tx_data !== 8'hA5) begin
      failures++; $display("FAIL single_release: ok=%0d active=%b tx_data=%h, want 1/0/a5", ok, active, tx_data);
    end
  endtask

  task automatic compare_stream(input string name, input int base, input int n);
    exp_t e; obs_t o;
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = obs_q[base + k];
      checks++;
      if (o.g !== e.g || o.d !== e.d) begin
        failures++;
        $display("FAIL %s[%0d]: grant=%b data=%h, want grant=%b data=%h", name, k, o.g, o.d, e.g, e.d);
      end
    end
    checks++;
    if (obs_q.size() != base + n) begin
      failures++; $display("FAIL %s_count: %0d launches, want %0d", name, obs_q.size() - base, n);
    end
  endtask

  task automatic test_atomic();
    bit ok; int base;
    do_reset();
    wtime = 3; tx_en = 1'b1;
    base = obs_q.size();
    @(posedge clk); #1;
    push_req(0, 8'h11, 1'b0);
    push_req(0, 8'h22, 1'b0);
    push_req(0, 8'h33, 1'b1);
    push_req(2, 8'h44, 1'b1);
    wait_obs(base + 4, 200, ok);
    wait_idle(60, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL atomic_idle: not idle after packets, grant=%b", grant);
    end
    compare_stream("atomic", base, 4);
  endtask

  task automatic test_round_robin();
    bit ok; int base;
    do_reset();
    wtime = 2; tx_en = 1'b1;
    base = obs_q.size();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
    for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'(8'h20 + i)});
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) begin
        exp_t e;
        e.g = 4'(1 << i); e.d = 8'(8'h10 + 16 * r + i);
        exp_q.push_back(e);
      end
    wait_obs(base + 8, 400, ok);
    wait_idle(60, ok);
    compare_stream("rr", base, 8);
  endtask

  task automatic test_timeout();
    bit ok; int base; int e0;
    do_reset();
    wtime = 3; tx_en = 1'b0;
    base = obs_q.size();
    e0 = err_cnt;
    @(posedge clk); #1;
    push_req(1, 8'h77, 1'b1);
    push_req(2, 8'h88, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (err_cnt > e0) begin ok = 1'b1; break; end
    end
    tx_en = 1'b1;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL timeout_err: no start_err within 30 cycles, want one");
    end
    wait_obs(base + 2, 40, ok);
    wait_idle(40, ok);
    checks++;
    if (obs_q.size() < base + 2 || err_cyc - obs_q[base].c != 4 || err_grant !== 4'd0) begin
      failures++; $display("FAIL timeout_timing: err at +%0d grant=%b, want +4/0000",
                           (obs_q.size() > base) ? err_cyc - obs_q[base].c : -1, err_grant);
    end
    checks++;
    if (obs_q.size() < base + 2 || obs_q[base + 1].c - err_cyc != 1) begin
      failures++; $display("FAIL timeout_next: next launch at +%0d after err, want +1",
                           (obs_q.size() > base + 1) ? obs_q[base + 1].c - err_cyc : -1);
    end
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++; $display("FAIL timeout_count: %0d start_err pulses, want 1", err_cnt - e0);
    end
    compare_stream("timeout", base, 2);
  endtask

  task automatic test_mid_reset();
    bit ok; int base;
    do_reset();
    wtime = 6; tx_en = 1'b1;
    base = obs_q.size();
    @(posedge clk); #1;
    push_req(2, 8'hC1, 1'b1);           // leaves ptr at 3
    wait_obs(base + 1, 20, ok);
    wait_idle(40, ok);
    push_req(2, 8'hA1, 1'b0);
    push_req(2, 8'hA2, 1'b0);
    rq[2].push_back({1'b1, 8'hA3});     // never launched: packet abandoned by reset
    wait_obs(base + 3, 60, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL midrst_launch: byte 2 not launched, launches=%0d want 3", obs_q.size() - base);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rq[2].delete();
    @(posedge clk); #1;
    checks++;
    if ({grant, ack, tx_flag, tx_data, active, start_err} !== {4'd0, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_outputs: grant=%b ack=%b flag=%b data=%h active=%b err=%b, want 0000 0000 0 ff 0 0",
               grant, ack, tx_flag, tx_data, active, start_err);
    end
    checks++;
    if (tx_busy !== 1'b1) begin
      failures++; $display("FAIL midrst_busy: transmitter busy=%b at reset, want 1", tx_busy);
    end
    rst_n = 1'b1;
    push_req(1, 8'h5C, 1'b1);           // ptr back at 0: requester 1 wins over 3
    push_req(3, 8'h3D, 1'b1);
    wait_obs(base + 5, 80, ok);
    wait_idle(60, ok);
    compare_stream("midrst", base, 5);
  endtask

  task automatic test_gap();
    bit ok; int n;
    do_reset();
    @(posedge clk); #1;
    g_req = 4'b0001; g_data[7:0] = 8'h5A; g_last = 4'b0000;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (g_flag) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok || g_txd !== 8'h5A || g_ack !== 4'b0001) begin
      failures++; $display("FAIL gap_first: ok=%0d data=%h ack=%b, want 1/5a/0001", ok, g_txd, g_ack);
    end
    g_data[7:0] = 8'h6B; g_last = 4'b0001;
    @(posedge clk); #1;
    g_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    g_busy = 1'b0;
    // Idle gap cycles, then SELECT, then the strobe cycle itself.
    n = 0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      n++;
      if (g_flag) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || n != GAPN + 2) begin
      failures++; $display("FAIL gap_spacing: strobe %0d cycles after busy fell, want %0d", n, GAPN + 2);
    end
    checks++;
    if (g_txd !== 8'h6B || g_ack !== 4'b0001) begin
      failures++; $display("FAIL gap_second: data=%h ack=%b, want 6b/0001", g_txd, g_ack);
    end
    g_req = 4'b0000;
    @(posedge clk); #1;
    g_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    g_busy = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (g_grant == 4'd0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || g_active !== 1'b0) begin
      failures++; $display("FAIL gap_release: grant=%b active=%b, want 0000/0", g_grant, g_active);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL invariants: %0d violations, want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_atomic();
    test_round_robin();
    test_timeout();
    test_mid_reset();
    test_gap();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
